// File: rtl/ifid_npc_stage.sv
// rtl/ifid_npc_stage.sv - Fetch PC register, next-PC selection and IF/ID pipeline register
// The instruction after a branch/jump always proceeds (architectural delay slot); nothing is flushed.
module ifid_npc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] im_instr,
    input  logic [2:0]  id_branch_type,
    input  logic        id_cmp_eq,
    input  logic        id_cmp_ltz,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic [31:0] id_jr_target,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc8,
    output logic        branch_taken
);

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLTZ = 3'd3;
    localparam logic [2:0] BR_BGEZ = 3'd4;

    logic [31:0] id_pc4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign id_pc4        = ifid_pc + 32'd4;
    assign ifid_pc8      = ifid_pc + 32'd8;
    // Word offset: sign-extended 16-bit immediate already shifted left by two.
    assign branch_offset = {{14{ifid_instr[15]}}, ifid_instr[15:0], 2'b00};
    assign branch_target = id_pc4 + branch_offset;
    assign jump_target   = {id_pc4[31:28], ifid_instr[25:0], 2'b00};

    always_comb begin
        branch_taken = 1'b0;
        case (id_branch_type)
            BR_BEQ:  branch_taken = id_cmp_eq;
            BR_BNE:  branch_taken = !id_cmp_eq;
            BR_BLTZ: branch_taken = id_cmp_ltz;
            BR_BGEZ: branch_taken = !id_cmp_ltz;
            default: branch_taken = 1'b0;
        endcase
    end

    // Stall is handled at the register enable; this is the unstalled choice.
    always_comb begin
        next_pc = pc + 32'd4;
        if (id_jr) begin
            next_pc = id_jr_target;
        end else if (id_jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP_WORD;
            ifid_pc    <= 32'd0;
        end else if (!stall) begin
            pc         <= next_pc;
            ifid_instr <= im_instr;
            ifid_pc    <= pc;
        end
    end

endmodule

// File: tb/tb_ifid_npc_stage.sv
// tb/tb_ifid_npc_stage.sv - Self-checking bench for ifid_npc_stage
module tb_ifid_npc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] im_instr;
    logic [2:0]  id_branch_type;
    logic        id_cmp_eq;
    logic        id_cmp_ltz;
    logic        id_jump;
    logic        id_jr;
    logic [31:0] id_jr_target;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc8;
    logic        branch_taken;

    int n_checks = 0;
    int n_fail   = 0;

    ifid_npc_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .im_instr(im_instr),
        .id_branch_type(id_branch_type), .id_cmp_eq(id_cmp_eq), .id_cmp_ltz(id_cmp_ltz),
        .id_jump(id_jump), .id_jr(id_jr), .id_jr_target(id_jr_target),
        .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc8(ifid_pc8),
        .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] at_pc;
        logic [31:0] instr;
        logic [2:0]  btype;
        logic        eq;
        logic        ltz;
        logic        jmp;
        logic        jr;
        logic [31:0] jr_tgt;
        logic [31:0] exp_pc;
        logic        exp_bt;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        id_branch_type = 3'd0;
        id_cmp_eq      = 1'b0;
        id_cmp_ltz     = 1'b0;
        id_jump        = 1'b0;
        id_jr          = 1'b0;
        id_jr_target   = 32'd0;
    endtask

    // Put word w into IF/ID at address at (via a jr redirect); afterwards pc = at + 4.
    task automatic load(input logic [31:0] at, input logic [31:0] w);
        clear_ctl();
        rst_n        = 1'b1;
        stall        = 1'b0;
        id_jr        = 1'b1;
        id_jr_target = at;
        im_instr     = 32'hFFFF_FFFF;
        step();
        clear_ctl();
        im_instr = w;
        step();
    endtask

    // Reference next fetch address, straight from the selection rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ipc,
                                             input logic [31:0] ii, input logic [2:0] bt,
                                             input logic eq, input logic ltz, input logic jmp,
                                             input logic jr, input logic [31:0] tgt);
        bit taken;
        int off;
        taken = (bt == 1 && eq) || (bt == 2 && !eq) || (bt == 3 && ltz) || (bt == 4 && !ltz);
        off   = int'($signed(ii[15:0])) * 4;
        if (jr)         return tgt;
        else if (jmp)   return ((ipc + 32'd4) & 32'hF000_0000) | (32'(ii[25:0]) * 32'd4);
        else if (taken) return ipc + 32'd4 + 32'(off);
        else            return cur_pc + 32'd4;
    endfunction

    function automatic logic ref_taken(input logic [2:0] bt, input logic eq, input logic ltz);
        return (bt == 1 && eq) || (bt == 2 && !eq) || (bt == 3 && ltz) || (bt == 4 && !ltz);
    endfunction

    logic [31:0] m_pc, m_ii, m_ipc, nx;

    initial begin
        //          name          at_pc          instr          ty eq lt jm jr jr_tgt         exp_pc         bt
        vecs[0]  = '{"bltz_t",    32'h0000_3010, 32'h0400_FFFC, 3, 0, 1, 0, 0, 32'h0,         32'h0000_3004, 1};
        vecs[1]  = '{"bltz_nt",   32'h0000_3010, 32'h0400_FFFC, 3, 0, 0, 0, 0, 32'h0,         32'h0000_3018, 0};
        vecs[2]  = '{"beq_t",     32'h0000_3000, 32'h1000_0003, 1, 1, 0, 0, 0, 32'h0,         32'h0000_3010, 1};
        vecs[3]  = '{"bne_nt",    32'h0000_3000, 32'h1400_0003, 2, 1, 0, 0, 0, 32'h0,         32'h0000_3008, 0};
        vecs[4]  = '{"bgez_t",    32'h0000_3000, 32'h0401_0003, 4, 0, 0, 0, 0, 32'h0,         32'h0000_3010, 1};
        vecs[5]  = '{"bne_t",     32'h0000_3000, 32'h1400_0003, 2, 0, 0, 0, 0, 32'h0,         32'h0000_3010, 1};
        vecs[6]  = '{"bgez_nt",   32'h0000_3000, 32'h0401_0003, 4, 0, 1, 0, 0, 32'h0,         32'h0000_3008, 0};
        vecs[7]  = '{"jump",      32'h0000_3000, 32'h0800_0C40, 0, 0, 0, 1, 0, 32'h0,         32'h0000_3100, 0};
        vecs[8]  = '{"jr",        32'h0000_3000, 32'h03E0_0008, 0, 0, 0, 0, 1, 32'h0000_3abc, 32'h0000_3abc, 0};
        vecs[9]  = '{"jr_jump",   32'h0000_3000, 32'h0800_0C40, 1, 1, 0, 1, 1, 32'h0000_3abc, 32'h0000_3abc, 1};
        vecs[10] = '{"jump_beq",  32'h0000_3000, 32'h0800_0C40, 1, 1, 0, 1, 0, 32'h0,         32'h0000_3100, 1};
        vecs[11] = '{"type5",     32'h0000_3000, 32'h1000_0003, 5, 1, 1, 0, 0, 32'h0,         32'h0000_3008, 0};
        vecs[12] = '{"wrap_br",   32'h0000_0000, 32'h1000_8000, 1, 1, 0, 0, 0, 32'h0,         32'hFFFE_0004, 1};
        vecs[13] = '{"wrap_pc",   32'hFFFF_FFF8, 32'h0000_0000, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 0};

        // Reset dominates stall; release then runs sequentially.
        clear_ctl();
        rst_n    = 1'b0;
        stall    = 1'b1;
        im_instr = 32'h1234_5678;
        step();
        step();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_pc8", ifid_pc8, 32'h8);
        rst_n = 1'b1;
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            im_instr = 32'hA000_0000 + k;
            step();
            chk("seq_pc", pc, 32'h0000_3004 + 32'(4 * k));
            chk("seq_ifid_pc", ifid_pc, 32'h0000_3000 + 32'(4 * k));
            chk("seq_instr", ifid_instr, 32'hA000_0000 + k);
        end

        for (int i = 0; i < 14; i++) begin
            load(vecs[i].at_pc, vecs[i].instr);
            id_branch_type = vecs[i].btype;
            id_cmp_eq      = vecs[i].eq;
            id_cmp_ltz     = vecs[i].ltz;
            id_jump        = vecs[i].jmp;
            id_jr          = vecs[i].jr;
            id_jr_target   = vecs[i].jr_tgt;
            im_instr       = 32'hC0DE_0000 + i;
            #1;
            chk({vecs[i].name, "_taken"}, 32'(branch_taken), 32'(vecs[i].exp_bt));
            chk({vecs[i].name, "_pc8"}, ifid_pc8, vecs[i].at_pc + 32'd8);
            step();
            chk({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
            chk({vecs[i].name, "_slot"}, ifid_instr, 32'hC0DE_0000 + i);
            chk({vecs[i].name, "_slot_pc"}, ifid_pc, vecs[i].at_pc + 32'd4);
            clear_ctl();
        end

        // Stall with a taken beq in ID: everything frozen, redirect on release.
        load(32'h0000_3000, 32'h1000_0003);
        id_branch_type = 3'd1;
        id_cmp_eq      = 1'b1;
        stall          = 1'b1;
        im_instr       = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", pc, 32'h0000_3004);
            chk("stall_ifid_pc", ifid_pc, 32'h0000_3000);
            chk("stall_instr", ifid_instr, 32'h1000_0003);
        end
        stall = 1'b0;
        step();
        chk("unstall_pc", pc, 32'h0000_3010);
        chk("unstall_instr", ifid_instr, 32'hDEAD_BEEF);
        chk("unstall_ifid_pc", ifid_pc, 32'h0000_3004);
        clear_ctl();

        // Reset during a pending redirect discards it.
        load(32'h0000_3040, 32'h1000_0010);
        id_branch_type = 3'd1;
        id_cmp_eq      = 1'b1;
        rst_n          = 1'b0;
        step();
        chk("midrst_pc", pc, 32'h0000_3000);
        chk("midrst_instr", ifid_instr, 32'h0);
        clear_ctl();
        rst_n    = 1'b1;
        im_instr = 32'h0000_0001;
        step();
        chk("midrst_rel_pc", pc, 32'h0000_3004);
        chk("midrst_rel_ifid_pc", ifid_pc, 32'h0000_3000);

        // Randomized run against the reference model.
        for (int i = 0; i < 400; i++) begin
            rst_n          = (i == 0 || $urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            stall          = ($urandom_range(0, 3) == 0);
            im_instr       = $urandom;
            id_branch_type = 3'($urandom_range(0, 7));
            id_cmp_eq      = 1'($urandom);
            id_cmp_ltz     = 1'($urandom);
            id_jump        = ($urandom_range(0, 7) == 0);
            id_jr          = ($urandom_range(0, 9) == 0);
            id_jr_target   = $urandom;
            #1;
            if (i > 0) begin
                chk("rnd_taken", 32'(branch_taken), 32'(ref_taken(id_branch_type, id_cmp_eq, id_cmp_ltz)));
            end
            if (!rst_n) begin
                m_pc  = 32'h0000_3000;
                m_ii  = 32'h0;
                m_ipc = 32'h0;
            end else if (!stall) begin
                nx    = ref_next(m_pc, m_ipc, m_ii, id_branch_type, id_cmp_eq, id_cmp_ltz,
                                 id_jump, id_jr, id_jr_target);
                m_ipc = m_pc;
                m_ii  = im_instr;
                m_pc  = nx;
            end
            step();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_instr", ifid_instr, m_ii);
            chk("rnd_ifid_pc", ifid_pc, m_ipc);
            chk("rnd_pc8", ifid_pc8, m_ipc + 32'd8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_npc_stage.md
Name: ifid_npc_stage

Overview:
- Fetch-side PC register, next-PC selection and IF/ID pipeline register of the five-stage MIPS core.
- Consumes the ID-stage comparator results (equal, less-than-zero) and the ID decode branch/jump controls.
- Computes the redirect target from the instruction held in IF/ID.
- Architectural delay slot: the instruction after a branch/jump always proceeds; nothing is flushed.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into pc on reset; also the start of instruction memory.
- NOP_WORD, 32'h0000_0000, value loaded into ifid_instr on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- stall  input  1  from hazard unit; 1 = freeze pc and IF/ID.
- im_instr  input  32  instruction memory read data for address pc (combinational read).
- id_branch_type  input  3  decode of ifid_instr: 0 none, 1 beq, 2 bne, 3 bltz, 4 bgez, 5-7 treated as none.
- id_cmp_eq  input  1  ID comparator: forwarded rs == forwarded rt.
- id_cmp_ltz  input  1  ID comparator: forwarded rs < 0, signed.
- id_jump  input  1  ID instruction is j/jal.
- id_jr  input  1  ID instruction is jr/jalr.
- id_jr_target  input  32  forwarded rs value for jr.
- pc  output  32  current fetch address to instruction memory.
- ifid_instr  output  32  instruction registered into ID.
- ifid_pc  output  32  address of ifid_instr.
- ifid_pc8  output  32  ifid_pc + 8, the link value for jal/jalr.
- branch_taken  output  1  combinational: ID branch condition true this cycle.

Behaviour:
- Reset: at a rising clk with rst_n=0, set pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc=0. ifid_pc8 is combinational, so it reads 8. Reset overrides stall.
- A reset asserted mid-operation discards any pending redirect; fetch resumes at RESET_PC on the first edge with rst_n=1.
- branch_taken is combinational from current inputs:
  - type 1: eq
  - type 2: !eq
  - type 3: ltz
  - type 4: !ltz
  - otherwise 0
- Internal fields, all taken from ifid_instr: imm = sign-extended ifid_instr[15:0]; index = ifid_instr[25:0]; id_pc4 = ifid_pc + 4.
- next_pc priority, highest first:
  1. stall → pc holds.
  2. id_jr → id_jr_target, unmodified; low 2 bits are not forced.
  3. id_jump → {id_pc4[31:28], index, 2'b00}.
  4. branch_taken → id_pc4 + (imm << 2).
  5. otherwise → pc + 4.
- All address arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- If several of id_jr, id_jump and a branch are asserted together (illegal decode), the priority above is still applied deterministically.
- IF/ID update on each non-reset edge:
  - stall=0: ifid_instr <= im_instr, ifid_pc <= pc.
  - stall=1: both registers hold.
- Stall together with a taken branch/jump: stall wins. The ID instruction is held, and the redirect is taken on the first edge with stall=0 using the then-current comparator inputs.
- Redirect latency: the branch resolves in ID during cycle N. The delay-slot instruction, fetched in cycle N, enters IF/ID at edge N. pc equals the target in cycle N+1.
- No stall-only bubble insertion happens here; the ID/EX stage inserts the bubble.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with stall=1 → pc=0x3000, ifid_instr=0, ifid_pc=0; release → sequence 0x3000, 0x3004, 0x3008 with IF/ID one cycle behind.
- bltz taken: ifid_pc=0x3010, type=3, ltz=1, imm=0xFFFC → delay-slot word from 0x3014 enters IF/ID; next pc=0x3004; branch_taken=1. Repeat with ltz=0 → next pc=0x3018.
- beq/bne/bgez: ifid_pc=0x3000, imm=0x0003 → beq eq=1 gives 0x3010; bne eq=1 gives 0x3008 (pc+4 path, pc=0x3004); bgez ltz=0 gives 0x3010.
- Jumps: ifid_instr index=0x0000C40, ifid_pc=0x3000 → pc=0x0000_3100. jr with target 0x0000_3abc → pc=0x3abc. jr+jump simultaneous → 0x3abc. ifid_pc8 = 0x3008.
- Stall: stall=1 for 3 cycles with a taken beq in ID → pc and IF/ID frozen; on the release edge pc=target and IF/ID=delay slot.
- Wrap: pc=0xFFFF_FFFC, no branch → next pc=0x0000_0000. Taken branch at ifid_pc=0x0000_0000 with imm=0x8000 → target 0xFFFE_0004.
